// File: rtl/spi_peripheral_pkg.sv
// Shared constants for the memory-mapped SPI master: register offsets,
// STATUS bit positions and transfer-engine state encoding.
package spi_peripheral_pkg;

   localparam logic [1:0] REG_TX     = 2'd0;
   localparam logic [1:0] REG_RX     = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int ST_BUSY = 0;
   localparam int ST_RXV  = 1;
   localparam int ST_OVF  = 2;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_LOW  = 3'd2;
   localparam logic [2:0] S_HIGH = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/spi_peripheral_if.sv
// Memory-bus contract between the CPU core (master) and the SPI responder (slave).
interface spi_peripheral_if #(parameter int ADDR_WIDTH = 4);

   logic [ADDR_WIDTH-1:0] address;
   logic [31:0]           data_in;
   logic [3:0]            write_mask;
   logic [31:0]           data_out;
   logic                  bus_enable;
   logic                  write_enable;

   modport master (
      output address, data_in, write_mask, bus_enable, write_enable,
      input  data_out
   );

   modport slave (
      input  address, data_in, write_mask, bus_enable, write_enable,
      output data_out
   );

endinterface

// File: rtl/spi_half_period_timer.sv
// Reloadable down-counter; tick is high while the count sits at zero, so a
// reload with divisor d yields a tick every d+1 cycles.
module spi_half_period_timer (
   input  logic       raw_clk,
   input  logic       button_reset,
   input  logic [7:0] divisor,
   input  logic       reload,
   output logic       tick
);

   logic [7:0] cnt;

   always_ff @(posedge raw_clk or negedge button_reset) begin
      if (!button_reset)     cnt <= 8'd0;
      else if (reload)       cnt <= divisor;
      else if (cnt != 8'd0)  cnt <= cnt - 8'd1;
   end

   assign tick = (cnt == 8'd0);

endmodule

// File: rtl/spi_peripheral.sv
// Memory-mapped SPI mode-0 master: register decode, edge-detected writes,
// registered reads and an 8-bit MSB-first shift engine.
module spi_peripheral
   import spi_peripheral_pkg::*;
#(
   parameter int         ADDR_WIDTH      = 4,
   parameter logic [7:0] DIVISOR_DEFAULT = 8'd3
) (
   input  logic             raw_clk,
   input  logic             button_reset,
   spi_peripheral_if.slave  bus,
   output logic             spi_clk,
   output logic             spi_mosi,
   input  logic             spi_miso,
   output logic             spi_cs
);

   logic [ADDR_WIDTH-1:0] addr;
   logic [1:0]  sel;
   logic [2:0]  state;
   logic [7:0]  tx_shift, rx_shift, rx_data, divisor;
   logic [2:0]  bit_cnt;
   logic        cs_q, rx_valid, overflow, we_q;
   logic        wr_req, wr_stb, busy, tx_wr, tx_start;
   logic        ctrl_wr_lo, ctrl_wr_hi, st_wr;
   logic        tick, reload;
   logic [31:0] rdata;
   logic        unused_ok;

   assign addr = bus.address;
   assign sel  = addr[3:2];

   // The core holds its strobes for two raw_clk cycles; act on the first only.
   assign wr_req     = bus.bus_enable & bus.write_enable;
   assign wr_stb     = wr_req & ~we_q;
   assign busy       = (state != S_IDLE);
   assign tx_wr      = wr_stb & (sel == REG_TX) & ~bus.write_mask[0];
   assign tx_start   = tx_wr & ~busy;
   assign ctrl_wr_lo = wr_stb & (sel == REG_CTRL) & ~bus.write_mask[0];
   assign ctrl_wr_hi = wr_stb & (sel == REG_CTRL) & ~bus.write_mask[1];
   assign st_wr      = wr_stb & (sel == REG_STATUS) & ~bus.write_mask[0];

   assign reload = (state == S_LOAD) |
                   (((state == S_LOW) | (state == S_HIGH)) & tick);

   spi_half_period_timer u_timer (
      .raw_clk      (raw_clk),
      .button_reset (button_reset),
      .divisor      (divisor),
      .reload       (reload),
      .tick         (tick)
   );

   always_ff @(posedge raw_clk or negedge button_reset) begin
      if (!button_reset) begin
         state    <= S_IDLE;
         tx_shift <= 8'd0;
         rx_shift <= 8'd0;
         bit_cnt  <= 3'd0;
         spi_clk  <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (tx_start) begin
               tx_shift <= bus.data_in[7:0];
               state    <= S_LOAD;
            end
            S_LOAD: begin
               spi_mosi <= tx_shift[7];
               bit_cnt  <= 3'd7;
               state    <= S_LOW;
            end
            S_LOW: if (tick) begin
               spi_clk  <= 1'b1;
               rx_shift <= {rx_shift[6:0], spi_miso};
               state    <= S_HIGH;
            end
            S_HIGH: if (tick) begin
               spi_clk <= 1'b0;
               if (bit_cnt == 3'd0) begin
                  state <= S_DONE;
               end else begin
                  tx_shift <= {tx_shift[6:0], 1'b0};
                  spi_mosi <= tx_shift[6];
                  bit_cnt  <= bit_cnt - 3'd1;
                  state    <= S_LOW;
               end
            end
            S_DONE: begin
               spi_mosi <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Flag updates: a hardware set outranks a same-cycle W1C clear.
   always_ff @(posedge raw_clk or negedge button_reset) begin
      if (!button_reset) begin
         we_q     <= 1'b0;
         divisor  <= DIVISOR_DEFAULT;
         cs_q     <= 1'b1;
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
         overflow <= 1'b0;
      end else begin
         we_q <= wr_req;
         if (ctrl_wr_lo) divisor <= bus.data_in[7:0];
         if (ctrl_wr_hi) cs_q    <= bus.data_in[8];
         if (state == S_DONE) rx_data <= rx_shift;

         if (state == S_DONE)                      rx_valid <= 1'b1;
         else if (tx_start)                        rx_valid <= 1'b0;
         else if (st_wr && bus.data_in[ST_RXV])    rx_valid <= 1'b0;

         if (tx_wr && busy)                        overflow <= 1'b1;
         else if (st_wr && bus.data_in[ST_OVF])    overflow <= 1'b0;
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (sel)
         REG_RX:     rdata[7:0] = rx_data;
         REG_CTRL:   rdata[8:0] = {cs_q, divisor};
         REG_STATUS: begin
            rdata[ST_BUSY] = busy;
            rdata[ST_RXV]  = rx_valid;
            rdata[ST_OVF]  = overflow;
         end
         default:    rdata = 32'd0;
      endcase
   end

   always_ff @(posedge raw_clk or negedge button_reset) begin
      if (!button_reset)                           bus.data_out <= 32'd0;
      else if (bus.bus_enable && !bus.write_enable) bus.data_out <= rdata;
   end

   assign spi_cs = cs_q;

   assign unused_ok = &{1'b0, addr, bus.data_in[31:9], bus.write_mask[3:2]};

endmodule

// File: tb/tb_spi_peripheral.sv
// Randomized bench for spi_peripheral: register-level reference model,
// SPI slave model and scoreboards for MOSI bytes and bus reads.
module tb_spi_peripheral;
  import spi_peripheral_pkg::*;

  logic raw_clk = 1'b0;
  logic button_reset = 1'b0;
  logic spi_clk, spi_mosi, spi_miso, spi_cs;

  spi_peripheral_if #(.ADDR_WIDTH(4)) bus ();

  spi_peripheral #(.ADDR_WIDTH(4), .DIVISOR_DEFAULT(8'd3)) dut (
    .raw_clk      (raw_clk),
    .button_reset (button_reset),
    .bus          (bus),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_cs       (spi_cs)
  );

  always #5 raw_clk = ~raw_clk;

  int cyc = 0;
  always @(posedge raw_clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  // reference model of the register file
  logic [7:0] m_div, m_rx, m_pend_rx;
  logic       m_cs, m_rxv, m_ovf, m_busy;

  logic [7:0]  sl_byte = 8'h00;
  int          sl_idx = 8;
  int          last_wr, tx_start, exp_per;
  logic [7:0]  exp_tx_q[$];
  logic [31:0] rd_q[$];
  string       rd_nm[$];
  event        rd_ev;
  int          nbits = 0;
  logic [7:0]  mosi_bits;
  longint      last_t;

  assign spi_miso = (sl_idx < 8) ? sl_byte[7 - sl_idx] : 1'b0;
  always @(negedge spi_clk) sl_idx = sl_idx + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // MOSI scoreboard: a byte is assembled over 8 rising spi_clk edges
  always @(posedge spi_clk) begin
    if (nbits > 0) chk("spi_clk_period", int'((longint'($time) - last_t) / 10), exp_per);
    last_t = longint'($time);
    mosi_bits = {mosi_bits[6:0], spi_mosi};
    nbits = nbits + 1;
    if (nbits == 8) begin
      nbits = 0;
      if (exp_tx_q.size() == 0) begin
        n_chk++;
        $display("FAIL spi_byte: got 0x%02h, expected no transfer", mosi_bits);
      end else chk("spi_byte", {24'h0, mosi_bits}, {24'h0, exp_tx_q.pop_front()});
    end
  end
  always @(negedge button_reset) nbits = 0;

  // read scoreboard
  always @(rd_ev) begin
    if (rd_q.size() > 0) chk(rd_nm.pop_front(), bus.data_out, rd_q.pop_front());
  end

  function automatic logic [31:0] exp_reg(input logic [1:0] r);
    case (r)
      REG_RX:     return {24'h0, m_rx};
      REG_CTRL:   return {23'h0, m_cs, m_div};
      REG_STATUS: return {29'h0, m_ovf, m_rxv, m_busy};
      default:    return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_div = 8'd3; m_cs = 1'b1; m_rx = 8'h00; m_rxv = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
  endtask

  task automatic rd(input logic [1:0] r, input string nm);
    logic [31:0] rnd;
    rnd = $urandom();
    rd_q.push_back(exp_reg(r));
    rd_nm.push_back(nm);
    @(negedge raw_clk);
    bus.address = {r, rnd[1:0]};
    bus.write_enable = 1'b0;
    bus.bus_enable = 1'b1;
    repeat (2) @(negedge raw_clk);
    bus.bus_enable = 1'b0;
    ->rd_ev;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] m, input int hold);
    @(negedge raw_clk);
    bus.address = {r, 2'b00};
    bus.data_in = d;
    bus.write_mask = m;
    bus.write_enable = 1'b1;
    bus.bus_enable = 1'b1;
    last_wr = cyc;
    repeat (hold) @(negedge raw_clk);
    bus.bus_enable = 1'b0;
    bus.write_enable = 1'b0;
  endtask

  task automatic ctrl_wr(input logic [31:0] d, input logic [3:0] m);
    wr(REG_CTRL, d, m, 2);
    if (!m[0]) m_div = d[7:0];
    if (!m[1]) m_cs = d[8];
    chk("spi_cs", {31'h0, spi_cs}, {31'h0, m_cs});
  endtask

  task automatic tx(input logic [7:0] b, input logic [7:0] sb, input int hold);
    logic [31:0] rnd;
    logic started;
    rnd = $urandom();
    started = !m_busy;
    if (started) begin
      sl_byte = sb; sl_idx = 0;
      exp_tx_q.push_back(b);
      exp_per = 2 * (int'(m_div) + 1);
      m_pend_rx = sb; m_rxv = 1'b0; m_busy = 1'b1;
    end else m_ovf = 1'b1;
    wr(REG_TX, {rnd[31:8], b}, 4'b1110, hold);
    if (started) tx_start = last_wr;
  endtask

  // poll STATUS.busy; duration counted from the write-strobe edge
  task automatic finish_tx(input string nm);
    int dur;
    dur = -1;
    bus.address = {REG_STATUS, 2'b00};
    bus.write_enable = 1'b0;
    bus.bus_enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge raw_clk);
      if (bus.data_out[0] == 1'b0) begin
        dur = cyc - tx_start - 2;
        break;
      end
    end
    bus.bus_enable = 1'b0;
    chk(nm, dur, 2 + 16 * (int'(m_div) + 1));
    m_busy = 1'b0; m_rx = m_pend_rx; m_rxv = 1'b1;
  endtask

  initial begin
    logic [31:0] saved, rnd;
    bus.address = '0; bus.data_in = '0; bus.write_mask = 4'hF;
    bus.bus_enable = 1'b0; bus.write_enable = 1'b0;
    model_reset();
    repeat (2) @(negedge raw_clk);
    chk("rst_data_out", bus.data_out, 32'h0);
    chk("rst_spi_clk", {31'h0, spi_clk}, 32'h0);
    chk("rst_spi_mosi", {31'h0, spi_mosi}, 32'h0);
    chk("rst_spi_cs", {31'h0, spi_cs}, 32'h1);
    button_reset = 1'b1;
    rd(REG_RX, "rst_rx");
    rd(REG_CTRL, "rst_ctrl");
    rd(REG_STATUS, "rst_status");

    // default divisor, 0xA5 out, slave returns 0x3C
    tx(8'hA5, 8'h3C, 2);
    finish_tx("t1_busy_cycles");
    rd(REG_RX, "t1_rx");
    rd(REG_STATUS, "t1_status");

    // fastest clock, cs asserted
    ctrl_wr(32'h0, 4'b0000);
    rnd = $urandom();
    tx(8'hFF, rnd[7:0], 2);
    finish_tx("t2_busy_cycles");
    rd(REG_RX, "t2_rx");

    // write while busy: dropped, overflow, RX shows previous byte
    ctrl_wr(32'h3, 4'b0000);
    rnd = $urandom();
    tx(8'h11, rnd[7:0], 2);
    repeat (10) @(negedge raw_clk);
    tx(8'h22, 8'h00, 2);
    rd(REG_RX, "t3_rx_during");
    rd(REG_STATUS, "t3_status_busy");
    finish_tx("t3_busy_cycles");
    rd(REG_STATUS, "t3_status_ovf");
    wr(REG_STATUS, 32'h4, 4'b1110, 2);
    m_ovf = 1'b0;
    rd(REG_STATUS, "t3_status_w1c");

    // long-held write strobe starts a single transfer
    rnd = $urandom();
    tx(8'h5A, rnd[7:0], 4);
    finish_tx("t4_busy_cycles");
    rd(REG_STATUS, "t4_status");

    // byte-lane masking on CTRL, data_out hold
    ctrl_wr(32'h2, 4'b0000);
    rd(REG_CTRL, "t5_ctrl_pre");
    ctrl_wr(32'h100, 4'b1101);
    rd(REG_CTRL, "t5_ctrl_lane1");
    saved = exp_reg(REG_CTRL);
    ctrl_wr(32'h0FF, 4'b0000);
    chk("data_out_hold", bus.data_out, saved);

    // reset during bit 4
    ctrl_wr(32'h3, 4'b0000);
    rnd = $urandom();
    tx(8'hFF, rnd[7:0], 2);
    for (int i = 0; i < 500; i++) begin
      @(negedge raw_clk);
      if (nbits >= 4) break;
    end
    chk("t6_reached_bit4", {31'h0, nbits >= 4}, 32'h1);
    #2 button_reset = 1'b0;
    #1;
    chk("t6_spi_clk", {31'h0, spi_clk}, 32'h0);
    chk("t6_spi_mosi", {31'h0, spi_mosi}, 32'h0);
    chk("t6_spi_cs", {31'h0, spi_cs}, 32'h1);
    chk("t6_data_out", bus.data_out, 32'h0);
    model_reset();
    exp_tx_q.delete();
    @(negedge raw_clk);
    button_reset = 1'b1;
    rd(REG_STATUS, "t6_status");
    rd(REG_CTRL, "t6_ctrl");
    rd(REG_RX, "t6_rx");
    rnd = $urandom();
    tx(8'h96, rnd[7:0], 2);
    finish_tx("t6_busy_cycles");
    rd(REG_RX, "t6_rx_after");

    // randomized transfers
    for (int it = 0; it < 6; it++) begin
      logic [7:0] tb_byte, sb;
      rnd = $urandom();
      ctrl_wr({rnd[31:9], rnd[8], 6'h0, rnd[1:0]}, {rnd[5:4], 2'b00});
      rnd = $urandom();
      tb_byte = rnd[7:0]; sb = rnd[15:8];
      tx(tb_byte, sb, 2);
      finish_tx("rnd_busy_cycles");
      rd(REG_RX, "rnd_rx");
      rd(REG_STATUS, "rnd_status");
      if (rnd[16]) begin
        wr(REG_STATUS, 32'h2, 4'b1110, 2);
        m_rxv = 1'b0;
        rd(REG_STATUS, "rnd_status_w1c");
      end
    end

    repeat (4) @(negedge raw_clk);
    chk("tx_queue_drained", exp_tx_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
